asi_arb: RTL and testbench

Read/write burst arbiter for the AXI slave interface user-clock domain. Sits between the read channel engine and the write channel engine and their shared user memory port. It grants exactly one direction at a time and holds that grant for a whole burst. Strict priority is selectable, with a bounded-starvation override.

---
 rtl/asi_arb.sv | 119 +++++++++++
 tb/tb_asi_arb.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asi_arb.sv
// Read/write burst arbiter for the shared user memory port: one direction owns
// the port for a whole burst, with strict priority and a bounded-starvation override.
module asi_arb #(
  parameter int SLV_ARB  = 0,
  parameter int ARB_MAXB = 4,
  parameter int CW       = $clog2(ARB_MAXB + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m_arff_rvalid,
  input  logic       m_rbusy,
  input  logic       m_rlast,
  output logic       rgranted,
  input  logic       m_awff_rvalid,
  input  logic       m_wbusy,
  input  logic       m_wlast,
  output logic       wgranted,
  output logic [1:0] arb_owner,
  output logic       error_arb
);

  // CW collapses to 0 for strict priority; keep at least one counter bit.
  localparam int SW = (CW < 1) ? 1 : CW;
  localparam logic [SW-1:0] MAXB_V = SW'(ARB_MAXB);
  localparam logic [SW-1:0] ONE_V  = SW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_R_OWN = 2'b01,
    ST_W_OWN = 2'b10
  } state_t;

  localparam state_t PREF_ST = (SLV_ARB != 0) ? ST_R_OWN : ST_W_OWN;
  localparam state_t OTH_ST  = (SLV_ARB != 0) ? ST_W_OWN : ST_R_OWN;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_cnt;
  logic [SW-1:0] w_cnt_nxt;
  logic          r_rgranted;
  logic          r_wgranted;
  logic          r_err;
  logic          w_err_nxt;
  logic          w_pref_req;
  logic          w_oth_req;
  logic          w_take_oth;

  // Next-state, starvation counter and sticky protocol-error decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pref_req  = (SLV_ARB != 0) ? m_arff_rvalid : m_awff_rvalid;
    w_oth_req   = (SLV_ARB != 0) ? m_awff_rvalid : m_arff_rvalid;
    w_take_oth  = (ARB_MAXB != 0) && (r_cnt == MAXB_V);
    w_err_nxt   = r_err | (m_rbusy && (r_state != ST_R_OWN))
                        | (m_wbusy && (r_state != ST_W_OWN));
    case (r_state)
      ST_IDLE: begin
        if (w_pref_req && w_oth_req) begin
          if (w_take_oth) begin
            w_state_nxt = OTH_ST;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = PREF_ST;
            w_cnt_nxt   = (r_cnt == MAXB_V) ? r_cnt : r_cnt + ONE_V;
          end
        end else if (w_pref_req) begin
          w_state_nxt = PREF_ST;
          w_cnt_nxt   = '0;
        end else if (w_oth_req) begin
          w_state_nxt = OTH_ST;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_R_OWN: begin
        if (m_rbusy && m_rlast) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_R_OWN;
        end
      end
      ST_W_OWN: begin
        if (m_wbusy && m_wlast) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_W_OWN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counter, grant and error registers; grants track the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_rgranted <= 1'b0;
      r_wgranted <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rgranted <= (w_state_nxt == ST_R_OWN);
      r_wgranted <= (w_state_nxt == ST_W_OWN);
      r_err      <= w_err_nxt;
    end
  end

  assign rgranted  = r_rgranted;
  assign wgranted  = r_wgranted;
  assign arb_owner = r_state;
  assign error_arb = r_err;

endmodule

// File: tb/tb_asi_arb.sv
// Bench for asi_arb: three instances (W-pref max 2, R-pref strict, W-pref max 4),
// directed scenarios plus randomized legal engine traffic against a rule model.
module tb_asi_arb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rq, rb, rl, wq, wb, wl, rg, wg, er;
  logic [1:0] own [3];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  asi_arb #(.SLV_ARB(0), .ARB_MAXB(2)) u0 (
    .clk(clk), .rst_n(rst_n),
    .m_arff_rvalid(rq[0]), .m_rbusy(rb[0]), .m_rlast(rl[0]), .rgranted(rg[0]),
    .m_awff_rvalid(wq[0]), .m_wbusy(wb[0]), .m_wlast(wl[0]), .wgranted(wg[0]),
    .arb_owner(own[0]), .error_arb(er[0]));

  asi_arb #(.SLV_ARB(1), .ARB_MAXB(0)) u1 (
    .clk(clk), .rst_n(rst_n),
    .m_arff_rvalid(rq[1]), .m_rbusy(rb[1]), .m_rlast(rl[1]), .rgranted(rg[1]),
    .m_awff_rvalid(wq[1]), .m_wbusy(wb[1]), .m_wlast(wl[1]), .wgranted(wg[1]),
    .arb_owner(own[1]), .error_arb(er[1]));

  asi_arb #(.SLV_ARB(0), .ARB_MAXB(4)) u2 (
    .clk(clk), .rst_n(rst_n),
    .m_arff_rvalid(rq[2]), .m_rbusy(rb[2]), .m_rlast(rl[2]), .rgranted(rg[2]),
    .m_awff_rvalid(wq[2]), .m_wbusy(wb[2]), .m_wlast(wl[2]), .wgranted(wg[2]),
    .arb_owner(own[2]), .error_arb(er[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    rq = 3'b000; rb = 3'b000; rl = 3'b000;
    wq = 3'b000; wb = 3'b000; wl = 3'b000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_in();
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clr_in();
    rst_n = 1'b0;
    #7;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (own[i] !== 2'b00 || rg[i] !== 1'b0 || wg[i] !== 1'b0 || er[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset inst=%0d own=%b rg=%b wg=%b err=%b exp 00/0/0/0",
                 i, own[i], rg[i], wg[i], er[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_burst();
    logic [1:0] exp_seq [6];
    exp_seq = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    do_reset();
    rq[0] = 1'b1;
    checks++;
    if (own[0] !== exp_seq[0]) begin
      errors++;
      $display("FAIL rburst step=0 own=%b exp=%b", own[0], exp_seq[0]);
    end
    tick();
    rq[0] = 1'b0;
    for (int s = 1; s < 6; s++) begin
      checks++;
      if (own[0] !== exp_seq[s] || rg[0] !== (exp_seq[s] == 2'b01) || wg[0] !== 1'b0) begin
        errors++;
        $display("FAIL rburst step=%0d own=%b rg=%b wg=%b exp own=%b", s, own[0], rg[0], wg[0], exp_seq[s]);
      end
      rb[0] = (s < 5);
      rl[0] = (s == 4);
      if (s < 5) tick();
    end
    clr_in();
  endtask

  task automatic test_starvation();
    logic [1:0] exp_own;
    do_reset();
    rq[0] = 1'b1;
    wq[0] = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      if (c % 2 == 0) exp_own = 2'b00;
      else exp_own = (((c - 1) / 2) % 3 == 2) ? 2'b01 : 2'b10;
      checks++;
      if (own[0] !== exp_own || (rg[0] & wg[0]) !== 1'b0) begin
        errors++;
        $display("FAIL starve c=%0d own=%b rg=%b wg=%b exp own=%b", c, own[0], rg[0], wg[0], exp_own);
      end
      rb[0] = (exp_own == 2'b01); rl[0] = (exp_own == 2'b01);
      wb[0] = (exp_own == 2'b10); wl[0] = (exp_own == 2'b10);
      tick();
    end
    clr_in();
  endtask

  task automatic test_strict();
    logic [1:0] exp_own;
    int grants = 0;
    do_reset();
    rq[1] = 1'b1;
    wq[1] = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      exp_own = (c % 2 == 1) ? 2'b01 : 2'b00;
      checks++;
      if (own[1] !== exp_own || wg[1] !== 1'b0) begin
        errors++;
        $display("FAIL strict c=%0d own=%b wg=%b exp own=%b wg=0", c, own[1], wg[1], exp_own);
      end
      if (rg[1] === 1'b1) grants++;
      rb[1] = (exp_own == 2'b01); rl[1] = (exp_own == 2'b01);
      tick();
    end
    checks++;
    if (grants !== 20) begin
      errors++;
      $display("FAIL strict_count grants=%0d exp=20", grants);
    end
    clr_in();
  endtask

  task automatic test_no_preempt();
    do_reset();
    wq[2] = 1'b1;
    tick();
    wq[2] = 1'b0;
    wb[2] = 1'b1;
    tick();
    rq[2] = 1'b1;
    tick();
    checks++;
    if (own[2] !== 2'b10 || rg[2] !== 1'b0) begin
      errors++;
      $display("FAIL nopreempt_mid own=%b rg=%b exp 10/0", own[2], rg[2]);
    end
    wl[2] = 1'b1;
    tick();
    wb[2] = 1'b0; wl[2] = 1'b0;
    checks++;
    if (own[2] !== 2'b00 || rg[2] !== 1'b0 || wg[2] !== 1'b0) begin
      errors++;
      $display("FAIL nopreempt_gap own=%b rg=%b wg=%b exp 00/0/0", own[2], rg[2], wg[2]);
    end
    tick();
    checks++;
    if (own[2] !== 2'b01 || rg[2] !== 1'b1) begin
      errors++;
      $display("FAIL nopreempt_grant own=%b rg=%b exp 01/1", own[2], rg[2]);
    end
    rq[2] = 1'b0; rb[2] = 1'b1; rl[2] = 1'b1;
    tick();
    clr_in();
  endtask

  task automatic test_error();
    do_reset();
    rb[0] = 1'b1;
    tick();
    rb[0] = 1'b0;
    checks++;
    if (er[0] !== 1'b1 || own[0] !== 2'b00 || rg[0] !== 1'b0 || wg[0] !== 1'b0) begin
      errors++;
      $display("FAIL err_set err=%b own=%b rg=%b wg=%b exp 1/00/0/0", er[0], own[0], rg[0], wg[0]);
    end
    wq[0] = 1'b1;
    tick();
    wq[0] = 1'b0;
    checks++;
    if (own[0] !== 2'b10 || wg[0] !== 1'b1 || er[0] !== 1'b1) begin
      errors++;
      $display("FAIL err_grant own=%b wg=%b err=%b exp 10/1/1", own[0], wg[0], er[0]);
    end
    wb[0] = 1'b1; wl[0] = 1'b1;
    tick();
    clr_in();
    tick();
    checks++;
    if (er[0] !== 1'b1 || own[0] !== 2'b00) begin
      errors++;
      $display("FAIL err_sticky err=%b own=%b exp 1/00", er[0], own[0]);
    end
    do_reset();
    checks++;
    if (er[0] !== 1'b0) begin
      errors++;
      $display("FAIL err_clear err=%b exp 0", er[0]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rq[0] = 1'b1;
    tick();
    rq[0] = 1'b0;
    rb[0] = 1'b1;
    wq[0] = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rg[0] !== 1'b0 || wg[0] !== 1'b0 || own[0] !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_async rg=%b wg=%b own=%b exp 0/0/00", rg[0], wg[0], own[0]);
    end
    rb[0] = 1'b0;
    rq[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (own[0] !== 2'b10 || wg[0] !== 1'b1 || rg[0] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_w1 own=%b wg=%b rg=%b exp 10/1/0", own[0], wg[0], rg[0]);
    end
    wb[0] = 1'b1; wl[0] = 1'b1;
    tick();
    wb[0] = 1'b0; wl[0] = 1'b0;
    tick();
    checks++;
    if (own[0] !== 2'b10) begin
      errors++;
      $display("FAIL rstmid_w2 own=%b exp 10", own[0]);
    end
    clr_in();
  endtask

  task automatic test_random();
    int  pref_rd [3];
    int  maxb [3];
    int  m_own [3];
    int  m_cnt [3];
    int  m_err [3];
    int  rrem [3];
    int  wrem [3];
    bit  rpend [3];
    bit  wpend [3];
    bit  ract [3];
    bit  wact [3];
    bit  to_rd;
    bit  pref_pend;
    bit  oth_pend;
    pref_rd = '{0, 1, 0};
    maxb    = '{2, 0, 4};
    for (int i = 0; i < 3; i++) begin
      m_own[i] = 0; m_cnt[i] = 0; m_err[i] = 0; rrem[i] = 0; wrem[i] = 0;
      rpend[i] = 1'b0; wpend[i] = 1'b0; ract[i] = 1'b0; wact[i] = 1'b0;
    end
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (own[i] !== 2'(m_own[i]) || rg[i] !== (m_own[i] == 1) ||
            wg[i] !== (m_own[i] == 2) || er[i] !== 1'(m_err[i])) begin
          errors++;
          $display("FAIL random cyc=%0d inst=%0d own=%b rg=%b wg=%b err=%b exp own=%0d err=%0d",
                   cyc, i, own[i], rg[i], wg[i], er[i], m_own[i], m_err[i]);
        end
      end
      // Engines: request sticky until popped, then one beat per owned cycle.
      for (int i = 0; i < 3; i++) begin
        rq[i] = rpend[i];
        wq[i] = wpend[i];
        if (m_own[i] == 1) begin
          if (!ract[i]) begin
            ract[i] = 1'b1; rrem[i] = $urandom_range(1, 4); rpend[i] = 1'b0;
          end
          rb[i] = 1'b1; rl[i] = (rrem[i] == 1); rrem[i]--;
          if (rrem[i] == 0) ract[i] = 1'b0;
        end else begin
          rb[i] = 1'b0; rl[i] = 1'b0;
          if (!rpend[i] && $urandom_range(0, 2) == 0) rpend[i] = 1'b1;
        end
        if (m_own[i] == 2) begin
          if (!wact[i]) begin
            wact[i] = 1'b1; wrem[i] = $urandom_range(1, 4); wpend[i] = 1'b0;
          end
          wb[i] = 1'b1; wl[i] = (wrem[i] == 1); wrem[i]--;
          if (wrem[i] == 0) wact[i] = 1'b0;
        end else begin
          wb[i] = 1'b0; wl[i] = 1'b0;
          if (!wpend[i] && $urandom_range(0, 2) == 0) wpend[i] = 1'b1;
        end
      end
      // Reference rules: who owns next, how long the waiting side has starved.
      for (int i = 0; i < 3; i++) begin
        if ((rb[i] && m_own[i] != 1) || (wb[i] && m_own[i] != 2)) m_err[i] = 1;
        if (m_own[i] == 0) begin
          pref_pend = pref_rd[i] ? rq[i] : wq[i];
          oth_pend  = pref_rd[i] ? wq[i] : rq[i];
          if (pref_pend || oth_pend) begin
            if (pref_pend && oth_pend && maxb[i] != 0 && m_cnt[i] == maxb[i]) begin
              to_rd = !pref_rd[i];
              m_cnt[i] = 0;
            end else if (pref_pend) begin
              to_rd = pref_rd[i];
              m_cnt[i] = oth_pend ? ((m_cnt[i] + 1 > maxb[i]) ? maxb[i] : m_cnt[i] + 1) : 0;
            end else begin
              to_rd = !pref_rd[i];
              m_cnt[i] = 0;
            end
            m_own[i] = to_rd ? 1 : 2;
          end
        end else if (m_own[i] == 1) begin
          if (rb[i] && rl[i]) m_own[i] = 0;
        end else begin
          if (wb[i] && wl[i]) m_own[i] = 0;
        end
      end
      tick();
    end
    clr_in();
  endtask

  initial begin
    clr_in();
    test_reset();
    test_read_burst();
    test_starvation();
    test_strict();
    test_no_preempt();
    test_error();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
